// File: rtl/nn_pkg.sv
// Shared constants and types for the network front end.
// Holds the UART image loader framing values and FSM encoding.
package nn_pkg;

    localparam int         NUM_PIXELS = 784;
    localparam logic [7:0] SYNC_BYTE  = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2,
        READY = 2'd3
    } loader_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;

endpackage

// File: rtl/image_word_packer.sv
// Little-endian byte-to-word packer for the UART image loader.
// word_done_o fires combinationally with the fourth byte of a word.
module image_word_packer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o,
    output logic [1:0]  byte_idx_o
);

    logic [23:0] lane_q;
    logic [1:0]  idx_q;

    assign word_done_o = en_i && (idx_q == 2'd3);
    assign word_o      = {byte_i, lane_q};
    assign byte_idx_o  = idx_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lane_q <= '0;
            idx_q  <= '0;
        end else if (clear_i) begin
            idx_q  <= '0;
        end else if (en_i) begin
            idx_q <= idx_q + 2'd1;
            unique case (idx_q)
                2'd0: lane_q[7:0]   <= byte_i;
                2'd1: lane_q[15:8]  <= byte_i;
                2'd2: lane_q[23:16] <= byte_i;
                2'd3: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_image_loader.sv
// Assembles a sync/payload/XOR-checksum UART frame into the
// signed pixel array consumed by the layer-1 matrix multiply.
module uart_image_loader #(
    parameter int         NUM_WORDS      = nn_pkg::NUM_PIXELS,
    parameter logic [7:0] SYNC_BYTE      = nn_pkg::SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               image_ack,
    output logic signed [31:0] image_data [0:NUM_WORDS-1],
    output logic               image_valid,
    output logic [9:0]         word_count,
    output logic               frame_error,
    output logic [1:0]         error_code
);
    import nn_pkg::*;

    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [9:0]    LAST_WORD = 10'(NUM_WORDS - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    loader_state_e state_q, state_d;
    logic [9:0]    wcnt_q, wcnt_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          ferr_q, ferr_d;
    logic [1:0]    ecode_q, ecode_d;

    logic        is_sync;
    logic        pk_clear;
    logic        pk_en;
    logic        word_done;
    logic [31:0] word;
    logic [1:0]  byte_idx;

    assign is_sync  = rx_valid && (rx_data == SYNC_BYTE);
    assign pk_clear = (state_q == IDLE) && is_sync;
    assign pk_en    = (state_q == RECV) && rx_valid;

    image_word_packer u_packer (
        .clk         (clk),
        .resetn      (resetn),
        .clear_i     (pk_clear),
        .en_i        (pk_en),
        .byte_i      (rx_data),
        .word_o      (word),
        .word_done_o (word_done),
        .byte_idx_o  (byte_idx)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        csum_d  = csum_q;
        idle_d  = idle_q;
        ferr_d  = 1'b0;
        ecode_d = ecode_q;
        unique case (state_q)
            IDLE: begin
                if (is_sync) begin
                    state_d = RECV;
                    wcnt_d  = '0;
                    csum_d  = '0;
                    idle_d  = '0;
                    ecode_d = ERR_NONE;
                end
            end
            RECV, CHECK: begin
                if (rx_valid) begin
                    idle_d = '0;
                    if (state_q == RECV) begin
                        csum_d = csum_q ^ rx_data;
                        if (word_done) begin
                            wcnt_d = wcnt_q + 10'd1;
                            if (wcnt_q == LAST_WORD) state_d = CHECK;
                        end
                    end else if (rx_data == csum_q) begin
                        state_d = READY;
                    end else begin
                        state_d = IDLE;
                        wcnt_d  = '0;
                        ferr_d  = 1'b1;
                        ecode_d = ERR_CSUM;
                    end
                end else if (idle_q == TO_LAST) begin
                    // a byte arriving on the expiry cycle keeps the frame alive
                    state_d = IDLE;
                    wcnt_d  = '0;
                    ferr_d  = 1'b1;
                    ecode_d = ERR_TIMEOUT;
                end else begin
                    idle_d = idle_q + TW'(1);
                end
            end
            READY: begin
                if (image_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            csum_q  <= '0;
            idle_q  <= '0;
            ferr_q  <= 1'b0;
            ecode_q <= ERR_NONE;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            csum_q  <= csum_d;
            idle_q  <= idle_d;
            ferr_q  <= ferr_d;
            ecode_q <= ecode_d;
        end
    end

    // pixel store is left unreset; contents only matter once validated
    always_ff @(posedge clk) begin
        if (word_done) image_data[wcnt_q] <= word;
    end

    logic unused_idx;
    assign unused_idx = ^byte_idx;

    assign image_valid = (state_q == READY);
    assign word_count  = wcnt_q;
    assign frame_error = ferr_q;
    assign error_code  = ecode_q;

endmodule

// File: tb/tb_uart_image_loader.sv
// Scoreboard bench for uart_image_loader with a 100-cycle timeout.
module tb_uart_image_loader;

    localparam int         NW   = 784;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TO   = 100;

    logic               clk;
    logic               resetn;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               image_ack;
    logic signed [31:0] img [0:NW-1];
    logic               image_valid;
    logic [9:0]         word_count;
    logic               frame_error;
    logic [1:0]         error_code;

    uart_image_loader #(
        .NUM_WORDS      (NW),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .image_ack   (image_ack),
        .image_data  (img),
        .image_valid (image_valid),
        .word_count  (word_count),
        .frame_error (frame_error),
        .error_code  (error_code)
    );

    typedef struct packed {
        logic       is_err;
        logic [1:0] code;
        int         cyc;
    } evt_t;

    evt_t        sb [$];
    logic [31:0] exp_img [0:NW-1];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          last_acc = 0;
    logic        vld_prev  = 1'b0;
    logic        ferr_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int pat, input int i);
        logic [31:0] w;
        case (pat)
            0:       w = 32'(i - 123);
            1:       w = 32'd0;
            default: w = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_A5A5;
        endcase
        return w;
    endfunction

    task automatic set_model(input int pat);
        for (int i = 0; i < NW; i++) exp_img[i] = word_of(pat, i);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        last_acc = cyc;
    endtask

    task automatic send_frame(input int pat, input logic [7:0] cx,
                              input int nwords);
        logic [7:0]  cs;
        logic [31:0] w;
        cs = 8'h00;
        send_byte(SYNC);
        for (int i = 0; i < nwords; i++) begin
            w = word_of(pat, i);
            for (int b = 0; b < 4; b++) begin
                send_byte(w[8*b +: 8]);
                cs ^= w[8*b +: 8];
            end
        end
        if (nwords == NW) send_byte(cs ^ cx);
    endtask

    task automatic push_evt(input logic e, input logic [1:0] c,
                            input int at);
        evt_t ev;
        ev.is_err = e;
        ev.code   = c;
        ev.cyc    = at;
        sb.push_back(ev);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
        #1;
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_img(input string tag);
        int errs;
        errs = 0;
        for (int i = 0; i < NW; i++)
            if (img[i] !== exp_img[i]) errs++;
        check(tag, 32'(errs), 32'd0);
    endtask

    task automatic ack();
        image_ack = 1'b1;
        @(posedge clk);
        #1;
        image_ack = 1'b0;
        check("ack_valid", 32'(image_valid), 32'd0);
    endtask

    always @(negedge clk) begin
        evt_t e;
        if (frame_error || (image_valid && !vld_prev)) begin
            if (sb.size() == 0) begin
                check("sb_extra", {30'd0, frame_error, image_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("evt_kind", 32'(frame_error), 32'(e.is_err));
                check("evt_code", 32'(error_code), 32'(e.code));
                check("evt_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
        if (frame_error) check("ferr_width", 32'(ferr_prev), 32'd0);
        vld_prev  = image_valid;
        ferr_prev = frame_error;
    end

    initial begin
        resetn    = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        image_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(image_valid), 32'd0);
        check("rst_wcnt", 32'(word_count), 32'd0);
        check("rst_ferr", 32'(frame_error), 32'd0);
        check("rst_ecode", 32'(error_code), 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // good frame with signed ramp
        set_model(0);
        send_frame(0, 8'h00, NW);
        push_evt(1'b0, 2'd0, last_acc);
        drain("t1_drain", 20);
        check("t1_valid", 32'(image_valid), 32'd1);
        check("t1_ecode", 32'(error_code), 32'd0);
        check("t1_wcnt", 32'(word_count), 32'd784);
        check("t1_px0", img[0], 32'hFFFF_FF85);
        check("t1_px783", img[783], 32'd660);
        check_img("t1_img");

        // frame sent while holding a valid image is dropped
        send_frame(2, 8'h00, NW);
        repeat (5) @(posedge clk);
        #1;
        check("t5_valid", 32'(image_valid), 32'd1);
        check_img("t5_img_kept");
        rx_data  = SYNC;
        rx_valid = 1'b1;
        ack();
        rx_valid = 1'b0;
        check("t5_wcnt", 32'(word_count), 32'd784);

        // bad checksum
        send_frame(0, 8'h01, NW);
        push_evt(1'b1, 2'd2, last_acc);
        drain("t2_drain", 20);
        check("t2_valid", 32'(image_valid), 32'd0);
        check("t2_ecode", 32'(error_code), 32'd2);
        check("t2_wcnt", 32'(word_count), 32'd0);

        // timeout after a partial frame
        send_frame(0, 8'h00, 10);
        push_evt(1'b1, 2'd1, last_acc + TO);
        drain("t3_drain", TO + 50);
        check("t3_ecode", 32'(error_code), 32'd1);
        check("t3_wcnt", 32'(word_count), 32'd0);
        set_model(2);
        send_frame(2, 8'h00, NW);
        push_evt(1'b0, 2'd0, last_acc);
        drain("t3b_drain", 20);
        check("t3b_ecode", 32'(error_code), 32'd0);
        check_img("t3b_img");
        ack();

        // ack outside READY, garbage before sync, all-zero frame
        ack();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check("t4_idle_wcnt", 32'(word_count), 32'd784);
        set_model(1);
        send_frame(1, 8'h00, NW);
        push_evt(1'b0, 2'd0, last_acc);
        drain("t4_drain", 20);
        check("t4_valid", 32'(image_valid), 32'd1);
        check_img("t4_img");
        ack();

        // reset mid-frame
        send_frame(0, 8'h00, 400);
        check("t6_pre_wcnt", 32'(word_count), 32'd400);
        resetn = 1'b0;
        #1;
        check("t6_valid", 32'(image_valid), 32'd0);
        check("t6_wcnt", 32'(word_count), 32'd0);
        check("t6_ferr", 32'(frame_error), 32'd0);
        check("t6_ecode", 32'(error_code), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        set_model(0);
        send_frame(0, 8'h00, NW);
        push_evt(1'b0, 2'd0, last_acc);
        drain("t6b_drain", 20);
        check("t6b_valid", 32'(image_valid), 32'd1);
        check_img("t6b_img");

        repeat (3) @(posedge clk);
        #1;
        check("sb_final", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
